// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: operation encoding and the flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRL  = 3'b110,
    OP_SLTU = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic neg;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the operand sequencer, the ALU and the result consumer.
interface alu_pipe_if #(
  parameter int W = 4
);
  import alu_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  alu_op_e       op;
  logic          acc_sel;
  logic          acc_wr;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          zero;
  logic          carry;
  logic          ovf;
  logic          neg;
  logic [W-1:0]  acc;

  modport master (
    output in_valid, a, b, op, acc_sel, acc_wr, acc_clr, out_ready,
    input  in_ready, out_valid, y, zero, carry, ovf, neg, acc
  );

  modport slave (
    input  in_valid, a, b, op, acc_sel, acc_wr, acc_clr, out_ready,
    output in_ready, out_valid, y, zero, carry, ovf, neg, acc
  );

endinterface

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result and flags for one operation.
// Saturating add/sub is built only when ALU_PIPE_SAT_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] y,
  output alu_flags_t   flags
);

  localparam int SHW = $clog2(W);

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [SHW-1:0] shamt;
  logic           sh_big;
  logic [W-1:0]   res;
  logic           c;
  logic           o;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign shamt  = b[SHW-1:0];
  // The whole of b is the shift amount for range purposes; only the low bits steer the shifter.
  assign sh_big = ({1'b0, b} >= (W+1)'(W));

  always_comb begin
    res = '0;
    c   = 1'b0;
    o   = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum[W-1:0];
        c   = sum[W];
        o   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
`ifdef ALU_PIPE_SAT_EN
        if (c) res = '1;
`endif
      end
      OP_SUB: begin
        res = diff[W-1:0];
        c   = diff[W];
        o   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
`ifdef ALU_PIPE_SAT_EN
        if (c) res = '0;
`endif
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = sh_big ? '0 : (a << shamt);
      OP_SRL:  res = sh_big ? '0 : (a >> shamt);
      OP_SLTU: res = {{(W-1){1'b0}}, diff[W]};
      default: res = '0;
    endcase
  end

  assign y           = res;
  assign flags.zero  = (res == '0);
  assign flags.carry = c;
  assign flags.ovf   = o;
  assign flags.neg   = res[W-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready flow control and an operand/result accumulator.
// Optional build macro: ALU_PIPE_SAT_EN (saturating add/sub inside alu_core).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  logic         s1_valid;
  logic         s2_valid;
  logic [W-1:0] s1_y;
  logic [W-1:0] s2_y;
  alu_flags_t   s1_flags;
  alu_flags_t   s2_flags;
  logic [W-1:0] acc_q;
  logic [W-1:0] core_a;
  logic [W-1:0] core_y;
  alu_flags_t   core_flags;
  logic         s2_load;
  logic         s1_load;
  logic         accept;

  assign s2_load = !s2_valid || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign accept  = bus.in_valid && s1_load;
  assign core_a  = bus.acc_sel ? acc_q : bus.a;

  alu_core #(
    .W (W)
  ) u_core (
    .a     (core_a),
    .b     (bus.b),
    .op    (bus.op),
    .y     (core_y),
    .flags (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s1_flags <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_y     <= core_y;
        s1_flags <= core_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_flags <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y     <= s1_y;
        s2_flags <= s1_flags;
      end
    end
  end

  // Written at the accept edge so a following acc_sel transaction sees it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else if (bus.acc_clr)
      acc_q <= '0;
    else if (accept && bus.acc_wr)
      acc_q <= core_y;
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.y         = s2_y;
  assign bus.zero      = s2_flags.zero;
  assign bus.carry     = s2_flags.carry;
  assign bus.ovf       = s2_flags.ovf;
  assign bus.neg       = s2_flags.neg;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at W=4.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  alu_pipe_if #(.W(4)) bus ();

  alu_pipe #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input alu_op_e o, input logic [3:0] aa, input logic [3:0] bb,
                       input logic sel, input logic wr, input logic clr);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = aa;
    bus.b        = bb;
    bus.acc_sel  = sel;
    bus.acc_wr   = wr;
    bus.acc_clr  = clr;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    obs = {bus.y, bus.zero, bus.carry, bus.ovf, bus.neg};
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (obs !== 8'h00) $display("FAIL reset_y_flags got=%h want=00", obs);
    else pass_cnt++;
    total_cnt++;
    if (bus.acc !== 4'd0) $display("FAIL reset_acc got=%h want=0", bus.acc);
    else pass_cnt++;
    tick();
    #2 rst_n = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    else pass_cnt++;
  endtask

  // Table entry: {op[2:0], a[3:0], b[3:0], y[3:0], zero, carry, ovf, neg}
  task automatic test_arith();
    logic [18:0] tbl [13];
    logic [18:0] e;
    logic [7:0]  obs;
`ifdef ALU_PIPE_SAT_EN
    tbl[0]  = {OP_ADD,  4'd9,  4'd8, 8'b1111_0111};
    tbl[1]  = {OP_SUB,  4'd3,  4'd5, 8'b0000_1100};
    tbl[12] = {OP_ADD,  4'd15, 4'd1, 8'b1111_0101};
`else
    tbl[0]  = {OP_ADD,  4'd9,  4'd8, 8'b0001_0110};
    tbl[1]  = {OP_SUB,  4'd3,  4'd5, 8'b1110_0101};
    tbl[12] = {OP_ADD,  4'd15, 4'd1, 8'b0000_1100};
`endif
    tbl[2]  = {OP_SLTU, 4'd3,  4'd5, 8'b0001_0000};
    tbl[3]  = {OP_SLL,  4'd3,  4'd2, 8'b1100_0001};
    tbl[4]  = {OP_SRL,  4'd12, 4'd5, 8'b0000_1000};
    tbl[5]  = {OP_AND,  4'd10, 4'd5, 8'b0000_1000};
    tbl[6]  = {OP_ADD,  4'd7,  4'd1, 8'b1000_0011};
    tbl[7]  = {OP_SUB,  4'd5,  4'd3, 8'b0010_0000};
    tbl[8]  = {OP_SUB,  4'd8,  4'd1, 8'b0111_0010};
    tbl[9]  = {OP_XOR,  4'd15, 4'd5, 8'b1010_0001};
    tbl[10] = {OP_SRL,  4'd12, 4'd3, 8'b0001_0000};
    tbl[11] = {OP_SLL,  4'd1,  4'd4, 8'b0000_1000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      e = tbl[i];
      drive(1'b1, alu_op_e'(e[18:16]), e[15:12], e[11:8], 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
      obs = {bus.y, bus.zero, bus.carry, bus.ovf, bus.neg};
      total_cnt++;
      if (bus.out_valid !== 1'b1 || obs !== e[7:0])
        $display("FAIL arith[%0d] op=%0d a=%0d b=%0d got valid=%b y_zcvn=%b want valid=1 y_zcvn=%b",
                 i, e[18:16], e[15:12], e[11:8], bus.out_valid, obs, e[7:0]);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_y [4];
    exp_y = '{4'd3, 4'd8, 4'd7, 4'd9};
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1'b1, OP_XOR, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
        1: drive(1'b1, OP_ADD, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
        2: drive(1'b1, OP_SUB, 4'd9, 4'd2, 1'b0, 1'b0, 1'b0);
        3: drive(1'b1, OP_OR,  4'd8, 4'd1, 1'b0, 1'b0, 1'b0);
        default: drive(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      endcase
      if (c < 4) begin
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got=%b want=1", c, bus.in_ready);
        else pass_cnt++;
      end
      tick();
      if (c >= 1 && c <= 4) begin
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.y !== exp_y[c-1])
          $display("FAIL b2b_y[%0d] got valid=%b y=%0d want valid=1 y=%0d", c-1, bus.out_valid, bus.y, exp_y[c-1]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got=%b want=0", bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    acc_cnt = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive(1'b1, OP_SUB, 4'd5,  4'd3,  1'b0, 1'b0, 1'b0);
        1: drive(1'b1, OP_AND, 4'd12, 4'd10, 1'b0, 1'b0, 1'b0);
        default: drive(1'b1, OP_OR, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
      endcase
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (c == 2) begin
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_3rd got=%b want=0", bus.in_ready);
        else pass_cnt++;
      end
      if (c >= 2) begin
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.y !== 4'd2)
          $display("FAIL bp_hold[%0d] got valid=%b y=%0d want valid=1 y=2", c, bus.out_valid, bus.y);
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (acc_cnt !== 2) $display("FAIL bp_accepted got=%0d want=2", acc_cnt);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b want=1", bus.in_ready);
    else pass_cnt++;
    tick();
    drive(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.y !== 4'd8)
      $display("FAIL bp_second got valid=%b y=%0d want valid=1 y=8", bus.out_valid, bus.y);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.y !== 4'd3)
      $display("FAIL bp_third got valid=%b y=%0d want valid=1 y=3", bus.out_valid, bus.y);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_drain got=%b want=0", bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_accumulator();
    bus.out_ready = 1'b1;
    drive(1'b1, OP_ADD, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    total_cnt++;
    if (bus.acc !== 4'd3) $display("FAIL acc_first got=%0d want=3", bus.acc);
    else pass_cnt++;
    drive(1'b1, OP_ADD, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0);
    tick();
    total_cnt++;
    if (bus.acc !== 4'd5 || bus.y !== 4'd3)
      $display("FAIL acc_second got acc=%0d y=%0d want acc=5 y=3", bus.acc, bus.y);
    else pass_cnt++;
    // Clear with an accepted write: A still reads the pre-clear value 5.
    drive(1'b1, OP_ADD, 4'd0, 4'd1, 1'b1, 1'b1, 1'b1);
    tick();
    total_cnt++;
    if (bus.acc !== 4'd0 || bus.y !== 4'd5)
      $display("FAIL acc_clr_prio got acc=%0d y=%0d want acc=0 y=5", bus.acc, bus.y);
    else pass_cnt++;
    drive(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.y !== 4'd6)
      $display("FAIL acc_sel_before_clr got valid=%b y=%0d want valid=1 y=6", bus.out_valid, bus.y);
    else pass_cnt++;
    drive(1'b1, OP_ADD, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    total_cnt++;
    if (bus.acc !== 4'd4) $display("FAIL acc_reload got=%0d want=4", bus.acc);
    else pass_cnt++;
    drive(1'b0, OP_ADD, 4'd9, 4'd9, 1'b0, 1'b1, 1'b1);
    tick();
    total_cnt++;
    if (bus.acc !== 4'd0) $display("FAIL acc_clr_idle got=%0d want=0", bus.acc);
    else pass_cnt++;
    drive(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [7:0] obs;
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, OP_SUB, 4'd9, 4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.acc !== 4'd5)
      $display("FAIL mid_prefill got valid=%b ready=%b acc=%0d want valid=1 ready=0 acc=5",
               bus.out_valid, bus.in_ready, bus.acc);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.y, bus.zero, bus.carry, bus.ovf, bus.neg};
    total_cnt++;
    if (bus.out_valid !== 1'b0 || obs !== 8'h00 || bus.acc !== 4'd0)
      $display("FAIL mid_async_clear got valid=%b y_zcvn=%b acc=%0d want valid=0 y_zcvn=00000000 acc=0",
               bus.out_valid, obs, bus.acc);
    else pass_cnt++;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL mid_in_ready got=%b want=1", bus.in_ready);
    else pass_cnt++;
    drive(1'b1, OP_ADD, 4'd6, 4'd7, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL mid_no_stale got=%b want=0", bus.out_valid);
    else pass_cnt++;
    tick();
    obs = {bus.y, bus.zero, bus.carry, bus.ovf, bus.neg};
    total_cnt++;
    if (bus.out_valid !== 1'b1 || obs !== 8'b1101_0011)
      $display("FAIL mid_first_result got valid=%b y_zcvn=%b want valid=1 y_zcvn=11010011",
               bus.out_valid, obs);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_accumulator();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
